// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file.
//   XLEN_DEFAULT  - default data width
//   NREGS_DEFAULT - default architectural register count
//   AW_DEFAULT    - address width for the default register count
//   reg_addr_t    - register index at the default configuration
//   xlen_t        - data word at the default configuration
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register.
//   clk, rst_n - clock, synchronous active-low reset (clears every busy bit)
//   wr_en      - NWR write enables; an enabled write to a nonzero register
//                clears that register's busy bit at the next edge
//   wr_addr    - NWR write addresses
//   rsv_en     - issue reserves rsv_addr (sets its busy bit at the next edge)
//   rsv_addr   - register to mark busy
//   busy_vec   - registered scoreboard, bit 0 tied low
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic [NREGS-1:0]        busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clears first, so a same-cycle reservation (a newer producer) overrides.
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i] != '0)) begin
        busy_d[wr_addr[i]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with busy-bit scoreboard.
//   clk, rst_n - clock, synchronous active-low reset (clears data and busy)
//   rd_addr    - NRD read addresses
//   rd_data    - NRD combinational read data (x0 reads as zero)
//   rd_busy    - NRD pending-write flags for the addressed registers
//   wr_en      - NWR write enables (higher port index = younger, wins)
//   wr_addr    - NWR write addresses (writes to x0 dropped)
//   wr_data    - NWR write data
//   rsv_en     - reserve rsv_addr as the destination of an issued op
//   rsv_addr   - register to mark busy
//   busy_vec   - full registered scoreboard, bit 0 always zero
// With BYPASS=1 a read that matches a same-cycle write returns that write's
// data and reports not-busy; with BYPASS=0 the stored state is returned.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_DEFAULT,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NREGS-1:0]         busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  reg_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  // Ports applied in ascending order: the last matching port (youngest) wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i] != '0)) begin
        regs_d[wr_addr[i]] = wr_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_data[j] = regs_q[rd_addr[j]];
      rd_busy[j] = busy_vec[rd_addr[j]];
      if (BYPASS) begin
        // Ascending scan so the youngest matching write is the one seen.
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i] == rd_addr[j])) begin
            rd_data[j] = wr_data[i];
            rd_busy[j] = 1'b0;
          end
        end
      end
      if (rd_addr[j] == '0) begin
        rd_data[j] = '0;
        rd_busy[j] = 1'b0;
      end
    end
  end

endmodule
